// File: rtl/wb_write_queue.sv
// Register-file write port arbiter: primary WB writes win; secondary results queue.
// WBQ_BYPASS_EN lets a secondary result write in the same cycle when the port is idle.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    p_regwrite,
    input  logic [4:0]              p_writereg,
    input  logic [31:0]             p_writedata,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [4:0]              s_writereg,
    input  logic [31:0]             s_writedata,
    output logic                    regwrite,
    output logic [4:0]              writereg,
    output logic [31:0]             writedata,
    input  logic [4:0]              qreg1,
    input  logic [4:0]              qreg2,
    output logic                    pend1,
    output logic                    pend2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    logic p_act;
    logic q_any;
    logic byp;
    logic enq;
    logic deq;

    assign p_act   = p_regwrite && (p_writereg != 5'd0);
    assign q_any   = (cnt != '0);
    assign s_ready = !reset && (cnt < CW'(DEPTH));

`ifdef WBQ_BYPASS_EN
    assign byp = !reset && !q_any && !p_act && s_valid && (s_writereg != 5'd0);
`else
    assign byp = 1'b0;
`endif

    // Writes to r0 are handshaken but dropped; bypassed results never occupy a slot.
    assign enq = s_valid && s_ready && (s_writereg != 5'd0) && !byp;
    assign deq = !reset && !p_act && q_any;

    assign count = cnt;

    always_comb begin
        regwrite  = 1'b0;
        writereg  = 5'd0;
        writedata = 32'd0;
        if (!reset) begin
            if (p_act) begin
                regwrite  = 1'b1;
                writereg  = p_writereg;
                writedata = p_writedata;
            end else if (q_any) begin
                regwrite  = 1'b1;
                writereg  = q_reg[rd_ptr];
                writedata = q_data[rd_ptr];
            end else if (byp) begin
                regwrite  = 1'b1;
                writereg  = s_writereg;
                writedata = s_writedata;
            end
        end
    end

    // The head stays pending through the cycle it is being written.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_reg[i] == qreg1)) pend1 = 1'b1;
            if (q_vld[i] && (q_reg[i] == qreg2)) pend2 = 1'b1;
        end
        if (reset || (qreg1 == 5'd0)) pend1 = 1'b0;
        if (reset || (qreg2 == 5'd0)) pend2 = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            q_reg[wr_ptr]  <= s_writereg;
            q_data[wr_ptr] <= s_writedata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            q_vld  <= '0;
        end else begin
            if (enq) begin
                wr_ptr        <= wr_ptr + 1'b1;
                q_vld[wr_ptr] <= 1'b1;
            end
            if (deq) begin
                rd_ptr        <= rd_ptr + 1'b1;
                q_vld[rd_ptr] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
